// File: rtl/taillight_pkg.sv
// Shared definitions for the taillight controller: mode encoding, the
// sequencing-side lamp patterns, and small mode classification helpers.
package taillight_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    HAZARD    = 3'd3,
    BRAKE     = 3'd4,
    FOG       = 3'd5,
    BRK_LEFT  = 3'd6,
    BRK_RIGHT = 3'd7
  } mode_t;

  // Lamp pattern (a,b,c) = (inner, middle, outer) for each sequencing phase
  localparam logic [2:0] PAT_PH0 = 3'b000;
  localparam logic [2:0] PAT_PH1 = 3'b100;
  localparam logic [2:0] PAT_PH2 = 3'b110;
  localparam logic [2:0] PAT_PH3 = 3'b111;

  function automatic logic [2:0] phase_pattern(input logic [1:0] ph);
    logic [2:0] p;
    case (ph)
      2'd0:    p = PAT_PH0;
      2'd1:    p = PAT_PH1;
      2'd2:    p = PAT_PH2;
      default: p = PAT_PH3;
    endcase
    return p;
  endfunction

  function automatic logic is_turn(input mode_t m);
    return (m == LEFT) || (m == RIGHT) || (m == BRK_LEFT) || (m == BRK_RIGHT);
  endfunction

  // True when both modes sequence the same side (including identical modes)
  function automatic logic same_side(input mode_t a, input mode_t b);
    logic al, bl, ar, br;
    al = (a == LEFT)  || (a == BRK_LEFT);
    bl = (b == LEFT)  || (b == BRK_LEFT);
    ar = (a == RIGHT) || (a == BRK_RIGHT);
    br = (b == RIGHT) || (b == BRK_RIGHT);
    return (al && bl) || (ar && br);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Animation-step prescaler: counts 0..TICK_DIV-1 and flags the last count.
module tick_divider #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [15:0] count;

  assign tick = (count == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/taillight_controller.sv
// Taillight controller: prioritised lamp modes with sequenced turn signals,
// all state advancing only on prescaler step ticks.
module taillight_controller
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       brake,
  input  logic       fog,
  input  logic       hazard,
  output logic       la,
  output logic       lb,
  output logic       lc,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic [2:0] mode,
  output logic       step_tick
);

  mode_t      mode_q, nxt_mode, cand;
  logic [1:0] phase_q, nxt_phase, ph_inc;
  logic [2:0] left_q, right_q, nxt_left, nxt_right, pat;
  logic       one_turn;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (step_tick)
  );

  assign one_turn = left_req ^ right_req;

  always_comb begin
    cand = IDLE;
    if (hazard)
      cand = HAZARD;
    else if (brake && one_turn)
      cand = left_req ? BRK_LEFT : BRK_RIGHT;
    else if (brake)
      cand = BRAKE;
    else if (one_turn)
      cand = left_req ? LEFT : RIGHT;
    else if (fog)
      cand = FOG;
  end

  // Turn modes finish their sweep before changing, except for hazard and
  // same-side brake overlays which switch at once and keep the phase.
  always_comb begin
    ph_inc    = phase_q + 2'd1;
    nxt_mode  = mode_q;
    nxt_phase = ph_inc;
    if (is_turn(mode_q)) begin
      if (cand == HAZARD) begin
        nxt_mode  = HAZARD;
        nxt_phase = 2'd0;
      end else if ((ph_inc == 2'd0) || same_side(cand, mode_q)) begin
        nxt_mode = cand;
      end
    end else begin
      nxt_mode  = cand;
      nxt_phase = 2'd0;
    end
  end

  always_comb begin
    pat       = phase_pattern(nxt_phase);
    nxt_left  = '0;
    nxt_right = '0;
    case (nxt_mode)
      LEFT:      nxt_left = pat;
      RIGHT:     nxt_right = pat;
      HAZARD: begin
        if (mode_q == HAZARD) begin
          nxt_left  = ~left_q;
          nxt_right = ~right_q;
        end
      end
      BRAKE: begin
        nxt_left  = '1;
        nxt_right = '1;
      end
      FOG: begin
        nxt_left  = 3'b001;
        nxt_right = 3'b001;
      end
      BRK_LEFT: begin
        nxt_left  = pat;
        nxt_right = '1;
      end
      BRK_RIGHT: begin
        nxt_left  = '1;
        nxt_right = pat;
      end
      default: begin
        nxt_left  = '0;
        nxt_right = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= IDLE;
      phase_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else if (step_tick) begin
      mode_q  <= nxt_mode;
      phase_q <= nxt_phase;
      left_q  <= nxt_left;
      right_q <= nxt_right;
    end
  end

  assign {la, lb, lc} = left_q;
  assign {ra, rb, rc} = right_q;
  assign mode         = mode_q;

endmodule
